// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: RISC-V front end. Fetches 32-bit words over a registered
// req/ack handshake (one request outstanding) into a QDEPTH-entry queue.
// Ports:
//   clk, rst               clock, synchronous active-high reset
//   imem_req, imem_addr    registered fetch request and word address
//   imem_ack, imem_rdata   memory accept strobe and same-cycle read data
//   Instr, InstrPC         queue head word and its address (zero when empty)
//   InstrValid, InstrReady head valid / decode consume
//   PCSrc, PCTarget        branch redirect pulse and target address
module instr_fetch_unit #(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
    parameter int              QDEPTH   = 2
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ack,
    input  logic [31:0]     imem_rdata,
    output logic [31:0]     Instr,
    output logic [XLEN-1:0] InstrPC,
    output logic            InstrValid,
    input  logic            InstrReady,
    input  logic            PCSrc,
    input  logic [XLEN-1:0] PCTarget
);

    localparam int PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
    localparam int CW = $clog2(QDEPTH + 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_WAIT    = 2'd1,
        S_DISCARD = 2'd2
    } state_t;

    state_t          state;
    state_t          state_nx;
    logic [XLEN-1:0] fetch_pc;
    logic [XLEN-1:0] pc_nx;
    logic [XLEN-1:0] pc_inc;
    logic [XLEN-1:0] target;
    logic            req_nx;
    logic [XLEN-1:0] addr_nx;

    logic            ack;
    logic            push;
    logic            pop;
    logic            credit;
    logic [CW-1:0]   count;
    logic [CW-1:0]   count_nx;
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic [31:0]     mem_instr [QDEPTH];
    logic [XLEN-1:0] mem_pc    [QDEPTH];

    assign target = PCTarget & ~XLEN'(3);
    assign pc_inc = fetch_pc + XLEN'(4);
    assign ack    = imem_req & imem_ack;

    // Only a live fetch in WAIT lands in the queue; a redirect kills it.
    assign push = (state == S_WAIT) & ack & ~PCSrc;
    assign pop  = InstrValid & InstrReady & ~PCSrc;

    // Occupancy after this edge; a new request needs a free slot for its
    // data so that acks never have to be stalled.
    assign count_nx = count + CW'(push) - CW'(pop);
    assign credit   = count_nx < CW'(QDEPTH);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state logic
    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE: begin
                if (!PCSrc && credit) begin
                    state_nx = S_WAIT;
                end
            end
            S_WAIT: begin
                if (ack) begin
                    state_nx = (!PCSrc && credit) ? S_WAIT : S_IDLE;
                end else if (PCSrc) begin
                    state_nx = S_DISCARD;
                end
            end
            S_DISCARD: begin
                if (ack) begin
                    state_nx = S_IDLE;
                end
            end
            default: state_nx = S_IDLE;
        endcase
    end

    // Output logic: next values of the registered request and fetch PC
    always_comb begin
        req_nx  = imem_req;
        addr_nx = imem_addr;
        pc_nx   = fetch_pc;
        if (PCSrc) begin
            pc_nx = target;
        end
        case (state)
            S_IDLE: begin
                if (!PCSrc && credit) begin
                    req_nx  = 1'b1;
                    addr_nx = fetch_pc;
                end
            end
            S_WAIT: begin
                if (ack) begin
                    if (!PCSrc) begin
                        pc_nx  = pc_inc;
                        req_nx = credit;
                        if (credit) begin
                            addr_nx = pc_inc;
                        end
                    end else begin
                        req_nx = 1'b0;
                    end
                end
            end
            S_DISCARD: begin
                // Request stays up on the stale address until memory takes it.
                if (ack) begin
                    req_nx = 1'b0;
                end
            end
            default: req_nx = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc  <= RESET_PC;
            imem_req  <= 1'b0;
            imem_addr <= RESET_PC;
        end else begin
            fetch_pc  <= pc_nx;
            imem_req  <= req_nx;
            imem_addr <= addr_nx;
        end
    end

    // Queue control
    always_ff @(posedge clk) begin
        if (rst || PCSrc) begin
            count  <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            count <= count_nx;
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
        end
    end

    // Queue storage, no reset needed: entries are qualified by count
    always_ff @(posedge clk) begin
        if (!rst && push) begin
            mem_instr[wr_ptr] <= imem_rdata;
            mem_pc[wr_ptr]    <= fetch_pc;
        end
    end

    assign InstrValid = (count != '0);
    assign Instr      = InstrValid ? mem_instr[rd_ptr] : 32'h0;
    assign InstrPC    = InstrValid ? mem_pc[rd_ptr] : '0;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: directed bench for instr_fetch_unit.
// Main instance at RESET_PC=0, second instance at RESET_PC=FFFF_FFF8.
module tb_instr_fetch_unit;

    logic        clk;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] Instr;
    logic [31:0] InstrPC;
    logic        InstrValid;
    logic        InstrReady;
    logic        PCSrc;
    logic [31:0] PCTarget;

    logic        tie;
    logic        ack_drv;

    logic        w_req;
    logic [31:0] w_addr;
    logic [31:0] w_rdata;
    logic [31:0] w_instr;
    logic [31:0] w_pc;
    logic        w_valid;

    int checks;
    int errors;

    function automatic logic [31:0] word(input logic [31:0] a);
        return a ^ 32'h5A5A_0013;
    endfunction

    assign imem_ack   = tie ? imem_req : ack_drv;
    assign imem_rdata = word(imem_addr);
    assign w_rdata    = word(w_addr);

    instr_fetch_unit #(.XLEN(32), .RESET_PC(32'h0), .QDEPTH(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .imem_req  (imem_req),
        .imem_addr (imem_addr),
        .imem_ack  (imem_ack),
        .imem_rdata(imem_rdata),
        .Instr     (Instr),
        .InstrPC   (InstrPC),
        .InstrValid(InstrValid),
        .InstrReady(InstrReady),
        .PCSrc     (PCSrc),
        .PCTarget  (PCTarget)
    );

    instr_fetch_unit #(.XLEN(32), .RESET_PC(32'hFFFF_FFF8), .QDEPTH(2)) u_wrap (
        .clk       (clk),
        .rst       (rst),
        .imem_req  (w_req),
        .imem_addr (w_addr),
        .imem_ack  (w_req),
        .imem_rdata(w_rdata),
        .Instr     (w_instr),
        .InstrPC   (w_pc),
        .InstrValid(w_valid),
        .InstrReady(1'b1),
        .PCSrc     (1'b0),
        .PCTarget  (32'h0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic do_reset;
        @(negedge clk);
        rst = 1'b1; tie = 1'b0; ack_drv = 1'b0;
        InstrReady = 1'b0; PCSrc = 1'b0; PCTarget = 32'h0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset;
        @(negedge clk);
        rst = 1'b1; tie = 1'b1; ack_drv = 1'b1;
        InstrReady = 1'b1; PCSrc = 1'b1; PCTarget = 32'h40;
        repeat (2) @(negedge clk);
        checks++;
        if ({imem_req, imem_addr, InstrValid, Instr, InstrPC} !== {1'b0, 32'h0, 1'b0, 32'h0, 32'h0}) begin
            errors++;
            $display("FAIL reset_main got req=%b addr=%h v=%b i=%h pc=%h exp 0,0,0,0,0",
                     imem_req, imem_addr, InstrValid, Instr, InstrPC);
        end
        checks++;
        if ({w_req, w_addr, w_valid, w_pc} !== {1'b0, 32'hFFFF_FFF8, 1'b0, 32'h0}) begin
            errors++;
            $display("FAIL reset_wrap got req=%b addr=%h v=%b pc=%h exp 0,fffffff8,0,0",
                     w_req, w_addr, w_valid, w_pc);
        end
        rst = 1'b0;
    endtask

    task automatic test_stream;
        logic [31:0] ea;
        logic [31:0] ep;
        do_reset();
        tie = 1'b1; InstrReady = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            ea = 32'(4 * (k - 1));
            checks++;
            if ({imem_req, imem_addr} !== {1'b1, ea}) begin
                errors++;
                $display("FAIL stream_req k=%0d got req=%b addr=%h exp 1,%h", k, imem_req, imem_addr, ea);
            end
            if (k >= 2) begin
                ep = 32'(4 * (k - 2));
                checks++;
                if ({InstrValid, InstrPC, Instr} !== {1'b1, ep, word(ep)}) begin
                    errors++;
                    $display("FAIL stream_head k=%0d got v=%b pc=%h i=%h exp 1,%h,%h",
                             k, InstrValid, InstrPC, Instr, ep, word(ep));
                end
            end else begin
                checks++;
                if (InstrValid !== 1'b0) begin
                    errors++;
                    $display("FAIL stream_first_empty got v=%b exp 0", InstrValid);
                end
            end
        end
    endtask

    task automatic test_backpressure;
        do_reset();
        ack_drv = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({imem_req, imem_addr, InstrValid, InstrPC} !== {1'b1, 32'h4, 1'b1, 32'h0}) begin
            errors++;
            $display("FAIL bp_second got req=%b addr=%h v=%b pc=%h exp 1,4,1,0",
                     imem_req, imem_addr, InstrValid, InstrPC);
        end
        repeat (3) @(negedge clk);
        checks++;
        if ({imem_req, InstrValid, InstrPC} !== {1'b0, 1'b1, 32'h0}) begin
            errors++;
            $display("FAIL bp_full got req=%b v=%b pc=%h exp 0,1,0", imem_req, InstrValid, InstrPC);
        end
        InstrReady = 1'b1;
        @(negedge clk);
        checks++;
        if ({imem_req, imem_addr, InstrPC, Instr} !== {1'b1, 32'h8, 32'h4, word(32'h4)}) begin
            errors++;
            $display("FAIL bp_resume got req=%b addr=%h pc=%h i=%h exp 1,8,4,%h",
                     imem_req, imem_addr, InstrPC, Instr, word(32'h4));
        end
        @(negedge clk);
        checks++;
        if ({InstrValid, InstrPC} !== {1'b1, 32'h8}) begin
            errors++;
            $display("FAIL bp_pc8 got v=%b pc=%h exp 1,8", InstrValid, InstrPC);
        end
    endtask

    task automatic test_redirect_wait;
        logic [31:0] ex_req [5];
        logic [31:0] ex_adr [5];
        ex_req = '{32'd1, 32'd1, 32'd1, 32'd0, 32'd1};
        ex_adr = '{32'h0, 32'h0, 32'h0, 32'h0, 32'h100};
        do_reset();
        InstrReady = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            PCSrc = 1'b0; ack_drv = 1'b0;
            checks++;
            if (imem_req !== ex_req[k-1][0] || (ex_req[k-1][0] && imem_addr !== ex_adr[k-1])
                || InstrValid !== 1'b0) begin
                errors++;
                $display("FAIL redir_wait k=%0d got req=%b addr=%h v=%b exp %0d,%h,0",
                         k, imem_req, imem_addr, InstrValid, ex_req[k-1], ex_adr[k-1]);
            end
            if (k == 1) begin
                PCSrc = 1'b1; PCTarget = 32'h100;
            end
            if (k == 3 || k == 5) ack_drv = 1'b1;
        end
        @(negedge clk);
        ack_drv = 1'b0;
        checks++;
        if ({InstrValid, InstrPC, Instr} !== {1'b1, 32'h100, word(32'h100)}) begin
            errors++;
            $display("FAIL redir_deliver got v=%b pc=%h i=%h exp 1,100,%h",
                     InstrValid, InstrPC, Instr, word(32'h100));
        end
    endtask

    task automatic test_flush;
        do_reset();
        ack_drv = 1'b1;
        repeat (3) @(negedge clk);
        InstrReady = 1'b1; PCSrc = 1'b1; PCTarget = 32'h203;
        @(negedge clk);
        PCSrc = 1'b0;
        checks++;
        if ({InstrValid, Instr, InstrPC, imem_req} !== {1'b0, 32'h0, 32'h0, 1'b0}) begin
            errors++;
            $display("FAIL flush_empty got v=%b i=%h pc=%h req=%b exp 0,0,0,0",
                     InstrValid, Instr, InstrPC, imem_req);
        end
        @(negedge clk);
        checks++;
        if ({imem_req, imem_addr} !== {1'b1, 32'h200}) begin
            errors++;
            $display("FAIL flush_fetch got req=%b addr=%h exp 1,200", imem_req, imem_addr);
        end
        @(negedge clk);
        checks++;
        if ({InstrValid, InstrPC} !== {1'b1, 32'h200}) begin
            errors++;
            $display("FAIL flush_deliver got v=%b pc=%h exp 1,200", InstrValid, InstrPC);
        end
        do_reset();
        tie = 1'b1; InstrReady = 1'b1;
        repeat (3) @(negedge clk);
        PCSrc = 1'b1; PCTarget = 32'h300;
        @(negedge clk);
        PCSrc = 1'b0;
        checks++;
        if ({InstrValid, imem_req} !== {1'b0, 1'b0}) begin
            errors++;
            $display("FAIL flush_ack got v=%b req=%b exp 0,0", InstrValid, imem_req);
        end
        @(negedge clk);
        checks++;
        if ({imem_req, imem_addr} !== {1'b1, 32'h300}) begin
            errors++;
            $display("FAIL flush_ack_fetch got req=%b addr=%h exp 1,300", imem_req, imem_addr);
        end
        @(negedge clk);
        checks++;
        if ({InstrValid, InstrPC, imem_addr} !== {1'b1, 32'h300, 32'h304}) begin
            errors++;
            $display("FAIL flush_ack_deliver got v=%b pc=%h addr=%h exp 1,300,304",
                     InstrValid, InstrPC, imem_addr);
        end
    endtask

    task automatic test_wrap;
        logic [31:0] wa [5];
        wa = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000, 32'h0000_0004, 32'h0000_0008};
        do_reset();
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            checks++;
            if ({w_req, w_addr} !== {1'b1, wa[k-1]}) begin
                errors++;
                $display("FAIL wrap_addr k=%0d got req=%b addr=%h exp 1,%h", k, w_req, w_addr, wa[k-1]);
            end
            if (k >= 2) begin
                checks++;
                if ({w_valid, w_pc, w_instr} !== {1'b1, wa[k-2], word(wa[k-2])}) begin
                    errors++;
                    $display("FAIL wrap_head k=%0d got v=%b pc=%h i=%h exp 1,%h,%h",
                             k, w_valid, w_pc, w_instr, wa[k-2], word(wa[k-2]));
                end
            end
        end
    endtask

    task automatic test_reset_mid;
        do_reset();
        @(negedge clk);
        ack_drv = 1'b1;
        @(negedge clk);
        ack_drv = 1'b0;
        checks++;
        if ({imem_req, imem_addr, InstrValid} !== {1'b1, 32'h4, 1'b1}) begin
            errors++;
            $display("FAIL rmid_setup got req=%b addr=%h v=%b exp 1,4,1", imem_req, imem_addr, InstrValid);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if ({imem_req, imem_addr, InstrValid, Instr, InstrPC} !== {1'b0, 32'h0, 1'b0, 32'h0, 32'h0}) begin
            errors++;
            $display("FAIL rmid_reset got req=%b addr=%h v=%b i=%h pc=%h exp 0,0,0,0,0",
                     imem_req, imem_addr, InstrValid, Instr, InstrPC);
        end
        @(negedge clk);
        ack_drv = 1'b1;
        checks++;
        if ({imem_req, imem_addr, InstrValid} !== {1'b1, 32'h0, 1'b0}) begin
            errors++;
            $display("FAIL rmid_restart got req=%b addr=%h v=%b exp 1,0,0", imem_req, imem_addr, InstrValid);
        end
        @(negedge clk);
        ack_drv = 1'b0;
        checks++;
        if ({InstrValid, InstrPC, Instr} !== {1'b1, 32'h0, word(32'h0)}) begin
            errors++;
            $display("FAIL rmid_deliver got v=%b pc=%h i=%h exp 1,0,%h",
                     InstrValid, InstrPC, Instr, word(32'h0));
        end
    endtask

    initial begin
        checks = 0; errors = 0;
        rst = 1'b1; tie = 1'b0; ack_drv = 1'b0;
        InstrReady = 1'b0; PCSrc = 1'b0; PCTarget = 32'h0;
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect_wait();
        test_flush();
        test_wrap();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
